// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, default frame shape and
// the parity helper. Used by the transmitter and intended for the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_STOP_BITS = 1;

  // Parity over a zero-extended data word; odd=1 inverts to odd parity.
  function automatic logic uart_parity(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_buf.sv
// One-entry holding register in front of the UART shifter. Accepts a byte
// whenever empty, precomputes its parity, and releases it on pop.
module uart_tx_buf
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  input  logic                 pop,
  output logic                 tx_ready,
  output logic                 full,
  output logic [DATA_BITS-1:0] data,
  output logic                 parity
);

  logic                 full_r;
  logic [DATA_BITS-1:0] data_r;
  logic                 parity_r;
  logic                 accept_s;

  // A byte is taken only while the register is empty; pop needs it full,
  // so accept and pop can never coincide.
  assign accept_s = tx_valid && !full_r;

  // Holding register: capture on accept, release on pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full_r   <= 1'b0;
      data_r   <= '0;
      parity_r <= 1'b0;
    end else if (accept_s) begin
      full_r   <= 1'b1;
      data_r   <= tx_data;
      parity_r <= uart_parity(8'(tx_data), 1'(PARITY_ODD));
    end else if (pop) begin
      full_r   <= 1'b0;
    end
  end

  assign tx_ready = ~full_r;
  assign full     = full_r;
  assign data     = data_r;
  assign parity   = parity_r;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, stop bit(s).
// All line activity advances on the shared baud_tick strobe; a one-entry
// buffer lets the next byte follow the last stop bit with no idle gap.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int STOP_BITS  = UART_STOP_BITS,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  uart_state_e          state_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 par_r;
  logic [2:0]           bit_cnt_r;
  logic                 stop_cnt_r;
  logic                 tx_r;
  logic                 done_r;

  logic                 buf_full_s;
  logic                 buf_par_s;
  logic [DATA_BITS-1:0] buf_data_s;
  logic                 pop_s;

  uart_tx_buf #(
    .DATA_BITS  (DATA_BITS),
    .PARITY_ODD (PARITY_ODD)
  ) u_buf (
    .clk      (clk),
    .reset    (reset),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .pop      (pop_s),
    .tx_ready (tx_ready),
    .full     (buf_full_s),
    .data     (buf_data_s),
    .parity   (buf_par_s)
  );

  // Buffer is consumed on a tick from IDLE, or at the end of the last stop bit.
  always_comb begin
    pop_s = 1'b0;
    if (baud_tick && buf_full_s) begin
      case (state_r)
        IDLE:    pop_s = 1'b1;
        STOP:    pop_s = (stop_cnt_r == LAST_STOP);
        default: pop_s = 1'b0;
      endcase
    end else begin
      pop_s = 1'b0;
    end
  end

  // Frame sequencer: one line bit per baud tick, tx_done for one clk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      shift_r    <= '0;
      par_r      <= 1'b0;
      bit_cnt_r  <= 3'd0;
      stop_cnt_r <= 1'b0;
      tx_r       <= 1'b1;
      done_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (baud_tick) begin
        case (state_r)
          IDLE: begin
            if (buf_full_s) begin
              shift_r <= buf_data_s;
              par_r   <= buf_par_s;
              tx_r    <= 1'b0;
              state_r <= START;
            end else begin
              tx_r    <= 1'b1;
            end
          end
          START: begin
            tx_r      <= shift_r[0];
            shift_r   <= shift_r >> 1;
            bit_cnt_r <= 3'd0;
            state_r   <= DATA;
          end
          DATA: begin
            if (bit_cnt_r != LAST_BIT) begin
              tx_r      <= shift_r[0];
              shift_r   <= shift_r >> 1;
              bit_cnt_r <= bit_cnt_r + 3'd1;
            end else if (PARITY_EN != 0) begin
              tx_r      <= par_r;
              state_r   <= PARITY;
            end else begin
              tx_r       <= 1'b1;
              stop_cnt_r <= 1'b0;
              state_r    <= STOP;
            end
          end
          PARITY: begin
            tx_r       <= 1'b1;
            stop_cnt_r <= 1'b0;
            state_r    <= STOP;
          end
          STOP: begin
            if (stop_cnt_r != LAST_STOP) begin
              stop_cnt_r <= stop_cnt_r + 1'b1;
            end else begin
              done_r <= 1'b1;
              // Chain straight into the next start bit when a byte is waiting.
              if (buf_full_s) begin
                shift_r <= buf_data_s;
                par_r   <= buf_par_s;
                tx_r    <= 1'b0;
                state_r <= START;
              end else begin
                tx_r    <= 1'b1;
                state_r <= IDLE;
              end
            end
          end
          default: begin
            tx_r    <= 1'b1;
            state_r <= IDLE;
          end
        endcase
      end else begin
        state_r <= state_r;
      end
    end
  end

  assign tx      = tx_r;
  assign tx_done = done_r;
  assign tx_busy = (state_r != IDLE) || buf_full_s;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four configurations run side by side (8N1, 7 data/2 stop,
// 8 even parity, 8 odd parity). Accepted bytes become expected frames in a
// scoreboard queue; a line monitor rebuilds frames from tx and checks them,
// along with start timing, tx_done, tx_ready and tx_busy.
module tb_uart_tx;

  localparam int N = 4;

  function automatic int cfg_db(input int i);
    case (i) 1: return 7; default: return 8; endcase
  endfunction
  function automatic int cfg_sb(input int i);
    case (i) 1: return 2; default: return 1; endcase
  endfunction
  function automatic int cfg_pe(input int i);
    case (i) 2, 3: return 1; default: return 0; endcase
  endfunction
  function automatic int cfg_po(input int i);
    case (i) 3: return 1; default: return 0; endcase
  endfunction
  function automatic int flen(input int i);
    return 1 + cfg_db(i) + cfg_pe(i) + cfg_sb(i);
  endfunction

  // Expected line bits in transmit order, bit 0 = start bit.
  function automatic logic [15:0] make_frame(input logic [7:0] d, input int i);
    logic [15:0] f;
    int ones;
    int k;
    f = 16'h0000;
    ones = 0;
    k = 1;
    for (int b = 0; b < cfg_db(i); b++) begin
      f[k] = d[b];
      ones += int'(d[b]);
      k++;
    end
    if (cfg_pe(i) != 0) begin
      f[k] = (((ones + cfg_po(i)) % 2) == 1);
      k++;
    end
    for (int s = 0; s < cfg_sb(i); s++) begin
      f[k] = 1'b1;
      k++;
    end
    return f;
  endfunction

  logic clk;
  logic reset;
  logic baud_tick;
  logic [N-1:0] valid_all, ready_all, tx_all, busy_all, done_all;
  logic [7:0] data_all [N];

  int unsigned baud_div = 16;
  int unsigned div_cnt = 0;
  int unsigned gap_max = 0;
  bit align = 1'b0;

  logic [7:0]  stim_q [N][$];
  logic [15:0] exp_q [N][$];
  int unsigned acc_cnt [N];

  int errors = 0;
  int checks = 0;

  for (genvar g = 0; g < N; g++) begin : gen
    localparam int DB = cfg_db(g);
    logic       valid_s;
    logic [7:0] data_s;
    bit         got_it;
    int         n;

    assign valid_all[g] = valid_s;
    assign data_all[g]  = data_s;

    uart_tx #(
      .DATA_BITS  (cfg_db(g)),
      .STOP_BITS  (cfg_sb(g)),
      .PARITY_EN  (cfg_pe(g)),
      .PARITY_ODD (cfg_po(g))
    ) dut (
      .clk       (clk),
      .reset     (reset),
      .baud_tick (baud_tick),
      .tx_data   (data_s[DB-1:0]),
      .tx_valid  (valid_s),
      .tx_ready  (ready_all[g]),
      .tx        (tx_all[g]),
      .tx_busy   (busy_all[g]),
      .tx_done   (done_all[g])
    );

    // Producer: offers queued bytes, holds valid until accepted.
    initial begin
      valid_s = 1'b0;
      data_s  = 8'h00;
      forever begin
        @(negedge clk);
        #1;
        if (reset && stim_q[g].size() != 0 && (!align || baud_tick)) begin
          data_s  = stim_q[g].pop_front();
          valid_s = 1'b1;
          n = 0;
          forever begin
            @(posedge clk);
            got_it = ready_all[g] && reset;
            @(negedge clk);
            #1;
            if (got_it || !reset) break;
            n++;
            if (n > 5000) begin
              $display("FAIL accept_timeout inst%0d waited=%0d cycles limit=5000", g, n);
              $fatal(1);
            end
          end
          valid_s = 1'b0;
          data_s  = 8'($urandom);
          if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(negedge clk);
        end
      end
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Baud strobe: one clk high every baud_div clks (every clk when baud_div=1).
  initial begin
    baud_tick = 1'b0;
    forever begin
      @(negedge clk);
      if (div_cnt + 1 >= baud_div) begin
        div_cnt   = 0;
        baud_tick = 1'b1;
      end else begin
        div_cnt++;
        baud_tick = 1'b0;
      end
    end
  end

  // Scoreboard producer side: each accepted byte queues its expected frame.
  always @(posedge clk) begin
    for (int g = 0; g < N; g++) begin
      if (!reset) begin
        exp_q[g].delete();
        acc_cnt[g] <= 0;
      end else if (valid_all[g] && ready_all[g]) begin
        exp_q[g].push_back(make_frame(data_all[g], g));
        acc_cnt[g] <= acc_cnt[g] + 1;
      end
    end
  end

  task automatic chk(input bit ok, input string nm, input int g,
                     input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s inst%0d actual=%h required=%h at %0t", nm, g, act, req, $time);
    end
  endtask

  bit          in_frame [N];
  int          nbits [N];
  logic [15:0] got [N];
  bit          done_pend [N];
  int unsigned started [N];
  int unsigned done_cnt [N];
  int unsigned pend [N];
  logic        line_bit [N];

  // Line monitor: rebuilds frames one bit per tick and checks handshakes.
  initial begin
    bit tick;
    bit exp_done;
    logic [15:0] ef;
    for (int g = 0; g < N; g++) begin
      in_frame[g] = 1'b0; nbits[g] = 0; got[g] = 16'h0000; done_pend[g] = 1'b0;
      started[g] = 0; done_cnt[g] = 0; line_bit[g] = 1'b1;
    end
    forever begin
      @(posedge clk or negedge reset);
      tick = baud_tick;
      for (int g = 0; g < N; g++) pend[g] = acc_cnt[g] - started[g];
      #1;
      for (int g = 0; g < N; g++) begin
        if (!reset) begin
          chk(tx_all[g] == 1'b1, "reset_tx", g, 16'(tx_all[g]), 16'h1);
          chk(ready_all[g] == 1'b1, "reset_ready", g, 16'(ready_all[g]), 16'h1);
          chk(busy_all[g] == 1'b0, "reset_busy", g, 16'(busy_all[g]), 16'h0);
          chk(done_all[g] == 1'b0, "reset_done", g, 16'(done_all[g]), 16'h0);
          in_frame[g] = 1'b0; nbits[g] = 0; done_pend[g] = 1'b0;
          started[g] = 0; done_cnt[g] = 0; line_bit[g] = 1'b1;
        end else begin
          exp_done = tick && done_pend[g];
          chk(done_all[g] == exp_done, "tx_done", g, 16'(done_all[g]), 16'(exp_done));
          if (exp_done) begin
            done_pend[g] = 1'b0;
            done_cnt[g]++;
          end
          if (tick) begin
            if (in_frame[g]) begin
              got[g][nbits[g]] = tx_all[g];
              nbits[g]++;
              if (nbits[g] == flen(g)) begin
                in_frame[g]  = 1'b0;
                done_pend[g] = 1'b1;
                if (exp_q[g].size() == 0) begin
                  chk(1'b0 == 1'b1 && exp_q[g].size() != 0, "unexpected_frame", g, got[g], 16'h0);
                end else begin
                  ef = exp_q[g].pop_front();
                  chk(got[g] == ef, "frame", g, got[g], ef);
                end
              end
            end else begin
              chk(tx_all[g] == (pend[g] == 0), "start_timing", g,
                  16'(tx_all[g]), 16'(pend[g] == 0));
              if (tx_all[g] == 1'b0) begin
                in_frame[g] = 1'b1;
                got[g]      = 16'h0000;
                nbits[g]    = 1;
                started[g]++;
              end
            end
            line_bit[g] = tx_all[g];
          end else begin
            chk(tx_all[g] == line_bit[g], "tx_stable", g, 16'(tx_all[g]), 16'(line_bit[g]));
          end
          chk(ready_all[g] == (acc_cnt[g] == started[g]), "tx_ready", g,
              16'(ready_all[g]), 16'(acc_cnt[g] == started[g]));
          chk(busy_all[g] == (acc_cnt[g] != done_cnt[g]), "tx_busy", g,
              16'(busy_all[g]), 16'(acc_cnt[g] != done_cnt[g]));
        end
      end
    end
  end

  task automatic drain();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      #1;
      if (valid_all == '0 && busy_all == '0 && stim_q[0].size() == 0 &&
          stim_q[1].size() == 0 && stim_q[2].size() == 0 && stim_q[3].size() == 0) break;
      n++;
      if (n > 20000) begin
        $display("FAIL drain_timeout busy=%b waited=%0d cycles limit=20000", busy_all, n);
        $fatal(1);
      end
    end
    repeat (2 * baud_div + 2) @(negedge clk);
  endtask

  initial begin
    int n;
    reset = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;

    // Directed bytes: 0xA5 on 8N1, 0x55 on 7-data/2-stop, 0x07 on both parity builds.
    stim_q[0].push_back(8'hA5);
    stim_q[1].push_back(8'h55);
    stim_q[2].push_back(8'h07);
    stim_q[3].push_back(8'h07);
    drain();

    // Back-to-back pair: second byte waits in the buffer, no idle gap.
    for (int i = 0; i < N; i++) begin
      stim_q[i].push_back(8'h00);
      stim_q[i].push_back(8'hFF);
    end
    drain();

    // Offer exactly on a tick edge while idle.
    align = 1'b1;
    for (int i = 0; i < N; i++) stim_q[i].push_back(8'h3C);
    drain();
    align = 1'b0;

    // Random bytes with random gaps.
    gap_max = 40;
    for (int k = 0; k < 30; k++)
      for (int i = 0; i < N; i++) stim_q[i].push_back(8'($urandom));
    drain();

    // Tick held high every clk, then a short period.
    gap_max  = 3;
    baud_div = 1;
    for (int k = 0; k < 8; k++)
      for (int i = 0; i < N; i++) stim_q[i].push_back(8'($urandom));
    drain();
    baud_div = 3;
    for (int k = 0; k < 8; k++)
      for (int i = 0; i < N; i++) stim_q[i].push_back(8'($urandom));
    drain();
    baud_div = 16;
    gap_max  = 0;

    // Reset during data bit 3 with the next byte buffered.
    for (int i = 0; i < N; i++) begin
      stim_q[i].push_back(8'hC3);
      stim_q[i].push_back(8'h5A);
    end
    n = 0;
    while (tx_all[0] != 1'b0) begin
      @(negedge clk);
      n++;
      if (n > 200) begin
        $display("FAIL start_wait inst0 waited=%0d cycles limit=200", n);
        $fatal(1);
      end
    end
    repeat (16 * 4 + 8) @(negedge clk);
    #3 reset = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++) stim_q[i].delete();
    reset = 1'b1;
    repeat (16 * 30) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
